// File: rtl/seq_det_scheduler.sv
// Time-shared 4-bit overlapping Moore sequence detector serving NCH serial channels.
// A round-robin arbiter picks one channel per cycle, advances its saved context and writes it back.
module seq_det_scheduler #(
    parameter int          NCH     = 4,
    parameter logic [3:0]  PATTERN = 4'b1011,
    parameter int          CNT_W   = 16,
    localparam int         IDX_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NCH-1:0]   i_ch_valid,
    input  logic [NCH-1:0]   i_ch_bit,
    output logic [NCH-1:0]   o_ch_ready,
    input  logic [NCH-1:0]   i_ch_clr,
    input  logic             i_cfg_we,
    input  logic [3:0]       i_cfg_pattern,
    output logic [NCH-1:0]   o_z,
    output logic             o_det_valid,
    output logic [IDX_W-1:0] o_det_ch,
    output logic [CNT_W-1:0] o_hit_cnt
);

    typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4} stateT;

    stateT            r_ctx [NCH];
    stateT            w_ctxNext [NCH];
    stateT            w_newState;
    logic [3:0]       r_pattern;
    logic [IDX_W-1:0] r_ptr;
    logic             r_detValid;
    logic [IDX_W-1:0] r_detCh;
    logic [CNT_W-1:0] r_hitCnt;

    logic [NCH-1:0]   w_eligible;
    logic [NCH-1:0]   w_grant;
    logic [IDX_W-1:0] w_grantIdx;
    logic [IDX_W-1:0] w_scanIdx;
    logic             w_xfer;
    logic             w_detNext;

    // State k means the last k bits equal the first k pattern bits; the next state is the
    // longest suffix of (matched prefix, new bit) that is again a prefix of the pattern.
    function automatic stateT nextState(input logic [3:0] pat, input stateT cur, input logic b);
        logic [4:0] hist;
        logic [1:0] idx;
        logic       ok;
        int         k;
        stateT      res;
        k       = int'(cur);
        hist    = '0;
        hist[0] = b;
        for (int i = 1; i <= 4; i++) begin
            if (i <= k) begin
                idx     = 2'(3 - k + i);
                hist[i] = pat[idx];
            end
        end
        res = S0;
        for (int len = 1; len <= 4; len++) begin
            if (len <= k + 1) begin
                ok = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    if (j < len) begin
                        idx = 2'(4 - len + j);
                        if (hist[j] != pat[idx]) ok = 1'b0;
                    end
                end
                if (ok) res = stateT'(len);
            end
        end
        return res;
    endfunction

    always_comb begin
        w_eligible = i_ch_valid & ~i_ch_clr & {NCH{~i_cfg_we}};
        w_grant    = '0;
        w_grantIdx = '0;
        w_scanIdx  = '0;
        w_xfer     = 1'b0;
        // Scan starts just past the last granted channel so every requester gets a turn.
        for (int off = 1; off <= NCH; off++) begin
            w_scanIdx = IDX_W'((int'(r_ptr) + off) % NCH);
            if (!w_xfer && w_eligible[w_scanIdx]) begin
                w_xfer              = 1'b1;
                w_grantIdx          = w_scanIdx;
                w_grant[w_scanIdx]  = 1'b1;
            end
        end
    end

    always_comb begin
        w_ctxNext  = r_ctx;
        w_detNext  = 1'b0;
        w_newState = nextState(r_pattern, r_ctx[w_grantIdx], i_ch_bit[w_grantIdx]);
        if (i_cfg_we) begin
            for (int i = 0; i < NCH; i++) w_ctxNext[i] = S0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (i_ch_clr[i]) w_ctxNext[i] = S0;
            end
            if (w_xfer) begin
                w_ctxNext[w_grantIdx] = w_newState;
                w_detNext             = (w_newState == S4);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctx      <= '{default: S0};
            r_pattern  <= PATTERN;
            r_ptr      <= IDX_W'(NCH - 1);
            r_detValid <= 1'b0;
            r_detCh    <= '0;
            r_hitCnt   <= '0;
        end else begin
            r_ctx      <= w_ctxNext;
            r_detValid <= w_detNext;
            if (i_cfg_we) r_pattern <= i_cfg_pattern;
            if (w_xfer) r_ptr <= w_grantIdx;
            if (w_detNext) begin
                r_detCh <= w_grantIdx;
                if (r_hitCnt != {CNT_W{1'b1}}) r_hitCnt <= r_hitCnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_z = '0;
        for (int i = 0; i < NCH; i++) o_z[i] = (r_ctx[i] == S4);
    end

    assign o_ch_ready  = w_grant;
    assign o_det_valid = r_detValid;
    assign o_det_ch    = r_detCh;
    assign o_hit_cnt   = r_hitCnt;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: directed vector table, hand-written corner sequences and
// randomized traffic checked against a bit-history reference model.
module tb_seq_det_scheduler;

    localparam int NCH    = 4;
    localparam int CNT_W  = 3;
    localparam int HITMAX = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [NCH-1:0]   i_ch_valid, i_ch_bit, i_ch_clr;
    logic             i_cfg_we;
    logic [3:0]       i_cfg_pattern;
    logic [NCH-1:0]   o_ch_ready, o_z;
    logic             o_det_valid;
    logic [1:0]       o_det_ch;
    logic [CNT_W-1:0] o_hit_cnt;

    int errors = 0;
    int checks = 0;

    seq_det_scheduler #(.NCH(NCH), .PATTERN(4'b1011), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ch_valid(i_ch_valid), .i_ch_bit(i_ch_bit),
        .o_ch_ready(o_ch_ready), .i_ch_clr(i_ch_clr), .i_cfg_we(i_cfg_we),
        .i_cfg_pattern(i_cfg_pattern), .o_z(o_z), .o_det_valid(o_det_valid),
        .o_det_ch(o_det_ch), .o_hit_cnt(o_hit_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a channel matches when at least 4 bits arrived since its last clear
    // and the last 4 of them equal the pattern.
    logic [3:0] mHist [NCH];
    int         mCnt [NCH];
    logic [3:0] mPat;
    int         mPtr, mDetCh, mHit;
    logic       mDetV;

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin mHist[i] = '0; mCnt[i] = 0; end
        mPat = 4'b1011; mPtr = NCH - 1; mDetV = 1'b0; mDetCh = 0; mHit = 0;
    endtask

    function automatic int modelGrant(logic [3:0] v, logic [3:0] clr, logic cfg);
        if (cfg) return -1;
        for (int off = 1; off <= NCH; off++) begin
            int i = (mPtr + off) % NCH;
            if (v[i] && !clr[i]) return i;
        end
        return -1;
    endfunction

    task automatic modelUpdate(int g, logic [3:0] bits, logic [3:0] clr, logic cfg, logic [3:0] pat);
        mDetV = 1'b0;
        if (cfg) begin
            mPat = pat;
            for (int i = 0; i < NCH; i++) begin mHist[i] = '0; mCnt[i] = 0; end
        end else begin
            for (int i = 0; i < NCH; i++) if (clr[i]) begin mHist[i] = '0; mCnt[i] = 0; end
            if (g >= 0) begin
                mHist[g] = {mHist[g][2:0], bits[g]};
                if (mCnt[g] < 4) mCnt[g]++;
                mPtr = g;
                if (mCnt[g] == 4 && mHist[g] == mPat) begin
                    mDetV = 1'b1; mDetCh = g;
                    if (mHit < HITMAX) mHit++;
                end
            end
        end
    endtask

    function automatic logic [3:0] modelZ();
        logic [3:0] z = '0;
        for (int i = 0; i < NCH; i++) z[i] = (mCnt[i] == 4 && mHist[i] == mPat);
        return z;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(logic [3:0] v, logic [3:0] b, logic [3:0] c, logic cfg, logic [3:0] pat);
        @(negedge i_clk);
        i_ch_valid = v; i_ch_bit = b; i_ch_clr = c; i_cfg_we = cfg; i_cfg_pattern = pat;
        #1;
    endtask

    task automatic checkOutput(logic [3:0] expZ, logic expDet, int expDetCh, int expHit);
        chk("z", 32'(o_z), 32'(expZ));
        chk("det_valid", 32'(o_det_valid), 32'(expDet));
        if (expDet) chk("det_ch", 32'(o_det_ch), 32'(expDetCh));
        chk("hit_cnt", 32'(o_hit_cnt), 32'(expHit));
    endtask

    task automatic runModel(logic [3:0] v, logic [3:0] b, logic [3:0] c, logic cfg, logic [3:0] pat);
        int g;
        applyStimulus(v, b, c, cfg, pat);
        g = modelGrant(v, c, cfg);
        chk("ch_ready", 32'(o_ch_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge i_clk); #1;
        modelUpdate(g, b, c, cfg, pat);
        checkOutput(modelZ(), mDetV, mDetCh, mHit);
    endtask

    task automatic sendBits(int ch, logic [3:0] seqBits, int n);
        for (int k = n - 1; k >= 0; k--)
            runModel(4'(1 << ch), seqBits[k] ? 4'(1 << ch) : 4'b0000, 4'b0000, 1'b0, 4'b0000);
    endtask

    task automatic doReset(logic [3:0] v, logic [3:0] b);
        @(negedge i_clk);
        i_ch_valid = v; i_ch_bit = b; i_ch_clr = '0; i_cfg_we = 1'b0;
        i_rst_n = 1'b0;
        #1;
        checkOutput(4'b0000, 1'b0, 0, 0);
        chk("det_ch_rst", 32'(o_det_ch), 32'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        i_rst_n = 1'b1; i_ch_valid = '0; i_ch_bit = '0;
        modelReset();
    endtask

    typedef struct {
        logic [3:0] valid, bits, clr, expReady, expZ;
        logic       expDet;
        int         expDetCh;
        int         expHit;
    } vecT;

    vecT vecs [$];

    initial begin
        i_rst_n = 1'b0; i_ch_valid = '0; i_ch_bit = '0; i_ch_clr = '0;
        i_cfg_we = 1'b0; i_cfg_pattern = '0;
        modelReset();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput(4'b0000, 1'b0, 0, 0);
        chk("det_ch_init", 32'(o_det_ch), 32'd0);
        i_rst_n = 1'b1;

        // ch0 alone with 1011011 (overlap), then ch0/ch1 interleaved 1011 streams
        vecs.push_back('{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 0});
        vecs.push_back('{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 0});
        vecs.push_back('{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 0});
        vecs.push_back('{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b1, 0, 1});
        vecs.push_back('{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 1});
        vecs.push_back('{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 1});
        vecs.push_back('{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b1, 0, 2});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 0, 2});
        vecs.push_back('{4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 1'b0, 0, 2});
        vecs.push_back('{4'b0011, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 2});
        vecs.push_back('{4'b0011, 4'b0011, 4'b0000, 4'b0010, 4'b0000, 1'b0, 0, 2});
        vecs.push_back('{4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 2});
        vecs.push_back('{4'b0011, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 0, 2});
        vecs.push_back('{4'b0011, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 2});
        vecs.push_back('{4'b0011, 4'b0011, 4'b0000, 4'b0010, 4'b0000, 1'b0, 0, 2});
        vecs.push_back('{4'b0011, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 1'b1, 0, 3});
        vecs.push_back('{4'b0011, 4'b0011, 4'b0000, 4'b0010, 4'b0011, 1'b1, 1, 4});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b0, 0, 4});

        foreach (vecs[n]) begin
            int g;
            applyStimulus(vecs[n].valid, vecs[n].bits, vecs[n].clr, 1'b0, 4'b0000);
            g = modelGrant(vecs[n].valid, vecs[n].clr, 1'b0);
            chk("tbl_ready", 32'(o_ch_ready), 32'(vecs[n].expReady));
            @(posedge i_clk); #1;
            modelUpdate(g, vecs[n].bits, vecs[n].clr, 1'b0, 4'b0000);
            checkOutput(vecs[n].expZ, vecs[n].expDet, vecs[n].expDetCh, vecs[n].expHit);
        end

        // Reconfigure to 1101 while ch2 sits in S3
        runModel(4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b0000);
        sendBits(2, 4'b0101, 3);
        runModel(4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b1101);
        chk("cfg_ready", 32'(o_ch_ready), 32'd0);
        sendBits(2, 4'b1011, 4);
        chk("old_pat_nodet", 32'(o_det_valid), 32'd0);
        sendBits(2, 4'b1101, 4);
        chk("new_pat_det", 32'(o_det_valid), 32'd1);
        chk("new_pat_ch", 32'(o_det_ch), 32'd2);

        // Clear ch1 on its final pattern bit
        runModel(4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b0000);
        sendBits(1, 4'b0110, 3);
        runModel(4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0000);
        chk("clr_nodet", 32'(o_det_valid), 32'd0);
        chk("clr_z1", 32'(o_z[1]), 32'd0);

        // Reset pulse while ch3 is in S3 with a bit on the wire
        sendBits(3, 4'b0110, 3);
        doReset(4'b1000, 4'b1000);
        runModel(4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        sendBits(3, 4'b1011, 4);
        chk("post_rst_det", 32'(o_det_valid), 32'd1);
        chk("post_rst_ch", 32'(o_det_ch), 32'd3);

        // Nine overlapping matches on ch0 saturate the counter
        sendBits(0, 4'b1011, 4);
        for (int k = 0; k < 8; k++) sendBits(0, 4'b0011, 3);
        chk("hit_sat", 32'(o_hit_cnt), 32'(HITMAX));

        doReset(4'b0000, 4'b0000);
        for (int n = 0; n < 500; n++) begin
            logic [3:0] v, b, c, p;
            logic       cfg;
            v   = 4'($urandom);
            b   = 4'($urandom);
            c   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            cfg = ($urandom_range(0, 49) == 0);
            p   = 4'($urandom);
            runModel(v, b, c, cfg, p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
